// File: rtl/uart_pkg.sv
// Shared UART definitions: default widths and the layout of one stored
// receive entry. The receiver and the receive FIFO use the same defaults.
package uart_pkg;

    localparam int UART_DATA_BITS        = 8;
    localparam int RX_FIFO_DEPTH_DEFAULT = 16;

    // One received frame as stored in the FIFO. Status bits sit above the
    // payload, so the flat vector form is {parity_err, frame_err, data}.
    typedef struct packed {
        logic                      parity_err;
        logic                      frame_err;
        logic [UART_DATA_BITS-1:0] data;
    } rx_entry_t;

    localparam int RX_ENTRY_BITS = $bits(rx_entry_t);

endpackage : uart_pkg

// File: rtl/uart_fifo_mem.sv
// Storage array for the receive FIFO: one synchronous write port and one
// asynchronous read port. Contents are not reset; the pointer and count
// logic in the parent decides which entries are meaningful.
module uart_fifo_mem #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write the addressed entry when the parent commits a store.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Combinational read so the head entry falls through without a bubble.
    always_comb begin
        rdata = mem_q[raddr];
    end

endmodule : uart_fifo_mem

// File: rtl/uart_rx_fifo.sv
// Receive-side buffer behind the UART receiver. Each data_ready pulse
// offers one frame with its status bits; frames are kept in a
// first-word-fall-through FIFO and offered to the host on out_valid/out_ready.
//
// Handshake: out_valid is high whenever an entry is stored and does not
// depend on out_ready; the head is consumed on a clock edge where
// out_valid && out_ready. The head outputs read 0 while out_valid is low.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS,
    parameter int DEPTH     = RX_FIFO_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_BITS-1:0]     rx_data,
    input  logic                     data_ready,
    input  logic                     parity_err,
    input  logic                     frame_err,
    input  logic                     drop_errored,
    output logic [DATA_BITS-1:0]     out_data,
    output logic                     out_parity_err,
    output logic                     out_frame_err,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overrun,
    input  logic                     overrun_clear,
    output logic [7:0]               drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATA_BITS + 2;

    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overrun_q, overrun_d;
    logic [7:0]    drop_count_q, drop_count_d;

    logic          has_err;
    logic          discard;
    logic          full;
    logic          pop;
    logic          store;
    logic          lost;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] head_entry;

    // Decide what this cycle's push and pop do. A discarded frame is
    // handled before the full check, so it can never cause an overrun.
    always_comb begin
        has_err  = parity_err | frame_err;
        discard  = data_ready & drop_errored & has_err;
        full     = (count_q == COUNT_FULL);
        pop      = out_valid & out_ready;
        store    = data_ready & ~discard & (~full | pop);
        lost     = data_ready & ~discard & full & ~pop;
        wr_entry = {parity_err, frame_err, rx_data};
    end

    // Next-state for pointers, occupancy, sticky overrun and drop counter.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        overrun_d    = overrun_q;
        drop_count_d = drop_count_q;

        if (store) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        if (store && !pop) begin
            count_d = count_q + COUNT_ONE;
        end else if (pop && !store) begin
            count_d = count_q - COUNT_ONE;
        end

        // Set wins over clear so a loss in the clearing cycle is not hidden.
        if (lost) begin
            overrun_d = 1'b1;
        end else if (overrun_clear) begin
            overrun_d = 1'b0;
        end

        if (discard && drop_count_q != 8'hFF) begin
            drop_count_d = drop_count_q + 8'd1;
        end
    end

    // Control state register; reset empties the buffer immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overrun_q    <= 1'b0;
            drop_count_q <= 8'd0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overrun_q    <= overrun_d;
            drop_count_q <= drop_count_d;
        end
    end

    uart_fifo_mem #(
        .WIDTH (EW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (store),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_q),
        .rdata (head_entry)
    );

    // Present the head entry, forced to zero while the buffer is empty.
    always_comb begin
        out_valid      = (count_q != '0);
        out_data       = '0;
        out_parity_err = 1'b0;
        out_frame_err  = 1'b0;
        if (out_valid) begin
            out_data       = head_entry[DATA_BITS-1:0];
            out_frame_err  = head_entry[DATA_BITS];
            out_parity_err = head_entry[DATA_BITS+1];
        end
        count      = count_q;
        overrun    = overrun_q;
        drop_count = drop_count_q;
    end

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with a queue-based reference of the
// stored frames, overrun flag and drop counter.
module tb_uart_rx_fifo;

    localparam int DB    = 8;
    localparam int DEPTH = 16;

    logic          clk;
    logic          reset;
    logic [DB-1:0] rx_data;
    logic          data_ready;
    logic          parity_err;
    logic          frame_err;
    logic          drop_errored;
    logic [DB-1:0] out_data;
    logic          out_parity_err;
    logic          out_frame_err;
    logic          out_valid;
    logic          out_ready;
    logic [4:0]    count;
    logic          overrun;
    logic          overrun_clear;
    logic [7:0]    drop_count;

    uart_rx_fifo #(.DATA_BITS(DB), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .rx_data        (rx_data),
        .data_ready     (data_ready),
        .parity_err     (parity_err),
        .frame_err      (frame_err),
        .drop_errored   (drop_errored),
        .out_data       (out_data),
        .out_parity_err (out_parity_err),
        .out_frame_err  (out_frame_err),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .count          (count),
        .overrun        (overrun),
        .overrun_clear  (overrun_clear),
        .drop_count     (drop_count)
    );

    // Clock and reference state.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DB+1:0] exp_q[$];
    logic          exp_overrun;
    int            exp_drop;
    int            n_checks;
    int            n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every visible output against the reference.
    task automatic check_state(input string tag);
        logic [DB+1:0] head;
        head = (exp_q.size() != 0) ? exp_q[0] : '0;
        check({tag, ".count"},      32'(count),      32'(exp_q.size()));
        check({tag, ".out_valid"},  32'(out_valid),  32'(exp_q.size() != 0));
        check({tag, ".head"},       32'({out_parity_err, out_frame_err, out_data}), 32'(head));
        check({tag, ".overrun"},    32'(overrun),    32'(exp_overrun));
        check({tag, ".drop_count"}, 32'(drop_count), 32'(exp_drop));
    endtask

    // One clock cycle of stimulus, driven from the falling edge. The reference
    // is updated with the same rules the buffer must follow.
    task automatic cycle(input logic push, input logic [DB-1:0] d, input logic pe,
                         input logic fe, input logic do_pop, input logic clr);
        logic popping;
        logic full;
        logic lost;
        data_ready    = push;
        rx_data       = d;
        parity_err    = pe;
        frame_err     = fe;
        out_ready     = do_pop;
        overrun_clear = clr;
        popping = do_pop && (exp_q.size() != 0);
        full    = (exp_q.size() == DEPTH);
        lost    = 1'b0;
        if (popping) begin
            check("pop_head", 32'({out_parity_err, out_frame_err, out_data}), 32'(exp_q[0]));
        end
        if (push) begin
            if (drop_errored && (pe || fe)) begin
                if (exp_drop < 255) exp_drop++;
            end else if (full && !popping) begin
                lost = 1'b1;
            end else begin
                exp_q.push_back({pe, fe, d});
            end
        end
        if (popping) void'(exp_q.pop_front());
        if (lost) exp_overrun = 1'b1;
        else if (clr) exp_overrun = 1'b0;
        @(posedge clk);
        @(negedge clk);
        data_ready    = 1'b0;
        out_ready     = 1'b0;
        overrun_clear = 1'b0;
        parity_err    = 1'b0;
        frame_err     = 1'b0;
    endtask

    task automatic push(input logic [DB-1:0] d, input logic pe, input logic fe);
        cycle(1'b1, d, pe, fe, 1'b0, 1'b0);
    endtask

    task automatic pop1();
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) pop1();
        check_state(tag);
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        exp_overrun = 1'b0;
        exp_drop = 0;
        reset = 1'b1;
        rx_data = '0;
        data_ready = 1'b0;
        parity_err = 1'b0;
        frame_err = 1'b0;
        drop_errored = 1'b0;
        out_ready = 1'b0;
        overrun_clear = 1'b0;
        repeat (3) @(negedge clk);
        check_state("reset");
        reset = 1'b0;
        @(negedge clk);

        // Single frame: visible one cycle after the push, then consumed.
        push(8'hA5, 1'b0, 1'b0);
        check_state("single_push");
        pop1();
        check_state("single_pop");

        // Fill to capacity, then overflow.
        for (int i = 0; i < DEPTH; i++) push(8'(i), 1'b0, 1'b0);
        check_state("filled");
        push(8'h10, 1'b0, 1'b0);
        check_state("overflow");
        // Clear in the same cycle as a fresh loss: flag must stay set.
        cycle(1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 1'b1);
        check_state("clear_vs_set");
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_state("clear_alone");
        drain("drain_0_f");

        // Full with simultaneous push and pop: no loss, occupancy holds.
        for (int i = 0; i < DEPTH; i++) push(8'(8'h20 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
        check_state("full_push_pop");
        for (int i = 0; i < DEPTH - 1; i++) pop1();
        check_state("last_is_55");
        pop1();
        check_state("after_55");

        // Errored-frame discard, then errored frame kept when not dropping.
        drop_errored = 1'b1;
        push(8'h11, 1'b1, 1'b0);
        push(8'h22, 1'b0, 1'b0);
        push(8'h33, 1'b0, 1'b1);
        check_state("drop_mix");
        drop_errored = 1'b0;
        push(8'h44, 1'b0, 1'b1);
        check_state("keep_err");
        pop1();
        check_state("frame_err_head");
        pop1();

        // Back-to-back push/pop streaming with random payloads.
        push(8'($urandom_range(0, 255)), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++)
            cycle(1'b1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0);
        check_state("stream");
        drain("stream_drain");

        // Drop counter saturation.
        drop_errored = 1'b1;
        for (int i = 0; i < 300; i++)
            push(8'($urandom_range(0, 255)), 1'b1, 1'($urandom_range(0, 1)));
        check_state("drop_sat");
        drop_errored = 1'b0;

        // Mid-stream asynchronous reset.
        for (int i = 0; i < 5; i++) push(8'(8'h70 + i), 1'b0, 1'b0);
        check_state("five");
        reset = 1'b1;
        #1;
        exp_q.delete();
        exp_overrun = 1'b0;
        exp_drop = 0;
        check_state("async_reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        push(8'h77, 1'b0, 1'b0);
        check_state("post_reset_push");
        pop1();
        check_state("post_reset_pop");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_uart_rx_fifo
